// File: rtl/two_phase_clock_gen.sv
// -----------------------------------------------------------------------------
// two_phase_clock_gen
//
// Purpose:
//   Derives a non-overlapping two-phase clock pair (Phi1/_Phi1, Phi2/_Phi2)
//   from a single master clock. The pairs drive the Clk/_Clk transmission-gate
//   inputs of master-slave latches. A five-state machine and a phase counter
//   produce the waveform:
//
//       P1 (PH_CYCLES) -> G1 (GAP_CYCLES) -> P2 (PH_CYCLES) -> G2 (GAP_CYCLES)
//
//   This gives a period of 2*(PH_CYCLES+GAP_CYCLES) master cycles. Enable is
//   only checked when G2 ends. A stop request therefore always lets the
//   current period finish, and no phase is ever cut short.
//
//   State table:
//       state | meaning
//       IDLE  | stopped, both phases low
//       P1    | Phi1 high
//       G1    | dead time after Phi1, both phases low
//       P2    | Phi2 high
//       G2    | dead time after Phi2, both low; restart or stop decided here
//
// Ports:
//   Clk     in   master clock, rising-edge active
//   Reset   in   asynchronous, active-high reset
//   Enable  in   run request, sampled on rising Clk
//   Phi1    out  phase-1 clock
//   _Phi1   out  exact complement of Phi1
//   Phi2    out  phase-2 clock
//   _Phi2   out  exact complement of Phi2
//   Edge1   out  one-cycle pulse in the first cycle of every Phi1 high
//   Running out  high whenever the state machine is not in IDLE
// -----------------------------------------------------------------------------
module two_phase_clock_gen #(
    parameter int PH_CYCLES  = 4,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Enable,
    output logic Phi1,
    output logic _Phi1,
    output logic Phi2,
    output logic _Phi2,
    output logic Edge1,
    output logic Running
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (PH_CYCLES < 1) begin : g_bad_ph
        $error("two_phase_clock_gen: PH_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("two_phase_clock_gen: GAP_CYCLES must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("two_phase_clock_gen: CNT_W must be >= 1");
    end
    if ((longint'(PH_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_ph_too_wide
        $error("two_phase_clock_gen: CNT_W too small for PH_CYCLES");
    end
    if ((longint'(GAP_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_gap_too_wide
        $error("two_phase_clock_gen: CNT_W too small for GAP_CYCLES");
    end

    // Terminal counts: a state ends in the cycle where cnt reaches these values.
    localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        G1   = 3'd2,
        P2   = 3'd3,
        G2   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic             phi1_d;
    logic             phi2_d;
    logic             edge1_d;
    logic             running_d;

    // -------------------------------------------------------------------------
    // State, counter and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            Phi1    <= 1'b0;
            _Phi1   <= 1'b1;
            Phi2    <= 1'b0;
            _Phi2   <= 1'b1;
            Edge1   <= 1'b0;
            Running <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            // The complements come from the same decoded bit, so each pair
            // switches on the same edge and is never equal.
            Phi1    <= phi1_d;
            _Phi1   <= ~phi1_d;
            Phi2    <= phi2_d;
            _Phi2   <= ~phi2_d;
            Edge1   <= edge1_d;
            Running <= running_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (Enable) begin
                    state_next = P1;
                end
            end
            P1: begin
                if (cnt == PH_LAST) begin
                    state_next = G1;
                end
            end
            G1: begin
                if (cnt == GAP_LAST) begin
                    state_next = P2;
                end
            end
            P2: begin
                if (cnt == PH_LAST) begin
                    state_next = G2;
                end
            end
            G2: begin
                // This is the only place Enable is checked while running.
                // Any deassert or glitch earlier in the period has no effect.
                if (cnt == GAP_LAST) begin
                    state_next = Enable ? P1 : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Every exit from a running state is a change of state, so the counter
    // is cleared on each entry and never wraps inside a state. In IDLE it is
    // held at zero.
    always_comb begin
        cnt_next = cnt + CNT_W'(1);
        if ((state_next != state) || (state_next == IDLE)) begin
            cnt_next = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state. The outputs are registered, so they
    // change on the same edge as the state they describe.
    // -------------------------------------------------------------------------
    always_comb begin
        phi1_d    = 1'b0;
        phi2_d    = 1'b0;
        edge1_d   = 1'b0;
        running_d = 1'b0;
        unique case (state_next)
            IDLE: begin
                running_d = 1'b0;
            end
            P1: begin
                phi1_d    = 1'b1;
                running_d = 1'b1;
                // Pulse only on entry into P1, not for every cycle of it.
                edge1_d   = (state != P1);
            end
            G1: begin
                running_d = 1'b1;
            end
            P2: begin
                phi2_d    = 1'b1;
                running_d = 1'b1;
            end
            G2: begin
                running_d = 1'b1;
            end
            default: begin
                running_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_two_phase_clock_gen.sv
module tb_two_phase_clock_gen;

    localparam int PH_A   = 4;
    localparam int GAP_A  = 1;
    localparam int PER_A  = 2 * (PH_A + GAP_A);
    localparam int PH_B   = 1;
    localparam int GAP_B  = 2;
    localparam int PER_B  = 2 * (PH_B + GAP_B);
    localparam logic [5:0] RST_VAL = 6'b010100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, en_a, rst_b, en_b;
    logic phi1_a, nphi1_a, phi2_a, nphi2_a, edge1_a, running_a;
    logic phi1_b, nphi1_b, phi2_b, nphi2_b, edge1_b, running_b;
    logic [5:0] out_a, out_b;

    // {Phi1, _Phi1, Phi2, _Phi2, Edge1, Running}
    assign out_a = {phi1_a, nphi1_a, phi2_a, nphi2_a, edge1_a, running_a};
    assign out_b = {phi1_b, nphi1_b, phi2_b, nphi2_b, edge1_b, running_b};

    two_phase_clock_gen #(.PH_CYCLES(PH_A), .GAP_CYCLES(GAP_A), .CNT_W(8)) dut_a (
        .Clk(clk), .Reset(rst_a), .Enable(en_a),
        .Phi1(phi1_a), ._Phi1(nphi1_a), .Phi2(phi2_a), ._Phi2(nphi2_a),
        .Edge1(edge1_a), .Running(running_a)
    );

    two_phase_clock_gen #(.PH_CYCLES(PH_B), .GAP_CYCLES(GAP_B), .CNT_W(4)) dut_b (
        .Clk(clk), .Reset(rst_b), .Enable(en_b),
        .Phi1(phi1_b), ._Phi1(nphi1_b), .Phi2(phi2_b), ._Phi2(nphi2_b),
        .Edge1(edge1_b), .Running(running_b)
    );

    int checks = 0;
    int errors = 0;

    logic [5:0] q_a[$];
    logic [5:0] q_b[$];

    // Reference model: position within the period, not a state machine.
    bit run_a = 1'b0;
    int pos_a = 0;
    bit run_b = 1'b0;
    int pos_b = 0;

    function automatic logic [5:0] expect_out(bit run, int pos, int ph, int gap);
        logic p1, p2;
        p1 = run && (pos < ph);
        p2 = run && (pos >= ph + gap) && (pos < 2 * ph + gap);
        return {p1, ~p1, p2, ~p2, run && (pos == 0), run};
    endfunction

    // Drive Enable for one edge, advance the model, and push the expected
    // outputs. Returns 1 ns after the edge.
    task automatic tick_a(input bit en);
        en_a = en;
        if (!run_a) begin
            if (en) begin
                run_a = 1'b1;
                pos_a = 0;
            end
        end else if (pos_a == PER_A - 1) begin
            pos_a = 0;
            if (!en) run_a = 1'b0;
        end else begin
            pos_a++;
        end
        q_a.push_back(expect_out(run_a, pos_a, PH_A, GAP_A));
        @(posedge clk);
        #1;
    endtask

    task automatic tick_b(input bit en);
        en_b = en;
        if (!run_b) begin
            if (en) begin
                run_b = 1'b1;
                pos_b = 0;
            end
        end else if (pos_b == PER_B - 1) begin
            pos_b = 0;
            if (!en) run_b = 1'b0;
        end else begin
            pos_b++;
        end
        q_b.push_back(expect_out(run_b, pos_b, PH_B, GAP_B));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
        #12;
        exp = RST_VAL;
        checks++;
        if (out_a !== exp) begin
            errors++;
            $display("FAIL reset_a: got %b expected %b", out_a, exp);
        end
        checks++;
        if (out_b !== exp) begin
            errors++;
            $display("FAIL reset_b: got %b expected %b", out_b, exp);
        end
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Enable first raised three cycles after reset release.
    task automatic test_start_latency();
        logic [5:0] exp;
        for (int i = 0; i < 3; i++) begin
            tick_a(1'b0);
            exp = q_a.pop_front();
            checks++;
            if (out_a !== exp) begin
                errors++;
                $display("FAIL idle_hold cyc %0d: got %b expected %b", i, out_a, exp);
            end
        end
        tick_a(1'b1);
        exp = q_a.pop_front();
        checks++;
        if (out_a !== exp) begin
            errors++;
            $display("FAIL start_edge: got %b expected %b", out_a, exp);
        end
    endtask

    task automatic test_continuous();
        logic [5:0] exp;
        int edges;
        edges = 0;
        for (int i = 0; i < 3 * PER_A; i++) begin
            tick_a(1'b1);
            exp = q_a.pop_front();
            checks++;
            if (out_a !== exp) begin
                errors++;
                $display("FAIL continuous cyc %0d: got %b expected %b", i, out_a, exp);
            end
            if (edge1_a === 1'b1) edges++;
        end
        checks++;
        if (edges !== 3) begin
            errors++;
            $display("FAIL edge1_count: got %0d expected 3", edges);
        end
    endtask

    // One-cycle low pulse on Enable while in G1.
    task automatic test_enable_glitch();
        logic [5:0] exp;
        int guard;
        guard = 0;
        while (pos_a != PH_A && guard < 2 * PER_A) begin
            tick_a(1'b1);
            exp = q_a.pop_front();
            checks++;
            if (out_a !== exp) begin
                errors++;
                $display("FAIL glitch_pre: got %b expected %b", out_a, exp);
            end
            guard++;
        end
        tick_a(1'b0);
        exp = q_a.pop_front();
        checks++;
        if (out_a !== exp) begin
            errors++;
            $display("FAIL glitch_low: got %b expected %b", out_a, exp);
        end
        for (int i = 0; i < 2 * PER_A; i++) begin
            tick_a(1'b1);
            exp = q_a.pop_front();
            checks++;
            if (out_a !== exp || running_a !== 1'b1) begin
                errors++;
                $display("FAIL glitch_post cyc %0d: got %b expected %b", i, out_a, exp);
            end
        end
    endtask

    // Deassert Enable in the second cycle of P1; the period must finish.
    task automatic test_stop();
        logic [5:0] exp;
        int guard;
        int fall;
        guard = 0;
        while (!(run_a && pos_a == 1) && guard < 2 * PER_A) begin
            tick_a(1'b1);
            exp = q_a.pop_front();
            checks++;
            if (out_a !== exp) begin
                errors++;
                $display("FAIL stop_pre: got %b expected %b", out_a, exp);
            end
            guard++;
        end
        fall = -1;
        for (int i = 1; i <= 20; i++) begin
            tick_a(1'b0);
            exp = q_a.pop_front();
            checks++;
            if (out_a !== exp) begin
                errors++;
                $display("FAIL stop cyc %0d: got %b expected %b", i, out_a, exp);
            end
            if (fall < 0 && running_a === 1'b0) fall = i;
        end
        checks++;
        if (fall !== 9) begin
            errors++;
            $display("FAIL stop_latency: got %0d expected 9", fall);
        end
    endtask

    // Assert Reset in the middle of P2, away from any clock edge.
    task automatic test_reset_mid_p2();
        logic [5:0] exp;
        int guard;
        guard = 0;
        while (!(run_a && pos_a == PH_A + GAP_A + 1) && guard < 3 * PER_A) begin
            tick_a(1'b1);
            exp = q_a.pop_front();
            checks++;
            if (out_a !== exp) begin
                errors++;
                $display("FAIL rst_pre: got %b expected %b", out_a, exp);
            end
            guard++;
        end
        checks++;
        if (phi2_a !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_p2: got phi2 %b expected 1", phi2_a);
        end
        #2;
        rst_a = 1'b1;
        #1;
        exp = RST_VAL;
        checks++;
        if (out_a !== exp) begin
            errors++;
            $display("FAIL rst_async: got %b expected %b", out_a, exp);
        end
        run_a = 1'b0;
        pos_a = 0;
        q_a.delete();
        @(negedge clk);
        en_a = 1'b0;
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        tick_a(1'b0);
        exp = q_a.pop_front();
        checks++;
        if (out_a !== exp) begin
            errors++;
            $display("FAIL rst_release: got %b expected %b", out_a, exp);
        end
    endtask

    task automatic test_ph1_gap2();
        logic [5:0] exp;
        int overlaps;
        int guard;
        overlaps = 0;
        for (int i = 0; i < 1000; i++) begin
            tick_b(1'b1);
            exp = q_b.pop_front();
            checks++;
            if (out_b !== exp) begin
                errors++;
                $display("FAIL ph1gap2 cyc %0d: got %b expected %b", i, out_b, exp);
            end
            if ((phi1_b & phi2_b) !== 1'b0) overlaps++;
        end
        checks++;
        if (overlaps !== 0) begin
            errors++;
            $display("FAIL overlap: got %0d overlapping cycles expected 0", overlaps);
        end
        guard = 0;
        while (run_b && guard < 2 * PER_B) begin
            tick_b(1'b0);
            exp = q_b.pop_front();
            checks++;
            if (out_b !== exp) begin
                errors++;
                $display("FAIL ph1gap2_stop: got %b expected %b", out_b, exp);
            end
            guard++;
        end
        tick_b(1'b0);
        exp = q_b.pop_front();
        checks++;
        if (out_b !== exp) begin
            errors++;
            $display("FAIL ph1gap2_idle: got %b expected %b", out_b, exp);
        end
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_continuous();
        test_enable_glitch();
        test_stop();
        test_reset_mid_p2();
        test_ph1_gap2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
